rv_inst_encoder_loader: RTL

- Encoder counterpart to the CPU control decoder: turns compact instruction commands into 32-bit RV32I words and writes them sequentially into instruction memory.
- Used by the test harness and boot loader to fill imem before the core is released from reset.
- Covers exactly the decoded subset: add, sub, or, addi, ori, lw, sw, beq.

---
 rtl/rv_inst_encoder_loader.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/rv_inst_encoder_loader.sv
// rv_inst_encoder_loader
//   Turns compact instruction commands into RV32I words and writes them
//   sequentially into instruction memory. It covers add, sub, or, addi, ori,
//   lw, sw and beq. The test harness and boot loader use it to fill imem
//   before the core leaves reset.
//
// Parameters
//   ADDR_W : imem word-address width
//   DEPTH  : number of imem words (<= 2**ADDR_W)
//   BASE   : first word address written after start
//
// Ports
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : pulse, (re)starts a session at BASE
//   cmd_valid/ready    : command handshake
//   cmd_kind..cmd_last : command payload
//   imem_we/addr/wdata : registered write port, one word per cycle
//   busy, done, err    : session status (err is sticky until start)
//   count              : words written this session
//   checksum           : XOR of all words written (only with LOADER_CHECKSUM_EN)
//
// Optional build macro: LOADER_CHECKSUM_EN adds the checksum output.
module rv_inst_encoder_loader #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256,
  parameter int BASE   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_kind,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [12:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
`ifdef LOADER_CHECKSUM_EN
  output logic [31:0]       checksum,
`endif
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   SPAN   = (ADDR_W+1)'(DEPTH - BASE);
  localparam logic [ADDR_W:0]   ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  // DRAIN covers the cycle in which the final word sits on the imem port.
  // The block is still busy there but takes no new command.
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  state_t state;
  logic   ovf_pend;  // session ended by running out of space, not cmd_last

  function automatic logic [31:0] encode(
    input logic [2:0]  kind,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [12:0] imm
  );
    logic [31:0] w;
    case (kind)
      3'd0:    w = {7'b0000000, rs2, rs1, 3'b000, rd, OP_R};
      3'd1:    w = {7'b0100000, rs2, rs1, 3'b000, rd, OP_R};
      3'd2:    w = {7'b0000000, rs2, rs1, 3'b110, rd, OP_R};
      3'd3:    w = {imm[11:0], rs1, 3'b000, rd, OP_I};
      3'd4:    w = {imm[11:0], rs1, 3'b110, rd, OP_I};
      3'd5:    w = {imm[11:0], rs1, 3'b010, rd, OP_LD};
      3'd6:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], OP_ST};
      default: w = {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], OP_BR};
    endcase
    return w;
  endfunction

  // 12-bit formats need imm to sign-extend from bit 11. Branch offsets
  // must be even.
  function automatic logic imm_bad(input logic [2:0] kind, input logic [12:0] imm);
    logic b;
    if (kind == 3'd7)      b = imm[0];
    else if (kind >= 3'd3) b = imm[12] ^ imm[11];
    else                   b = 1'b0;
    return b;
  endfunction

  logic        accept;
  logic [31:0] enc;
  logic [ADDR_W:0] count_nx;

  // count doubles as the pointer offset from BASE
  assign cmd_ready = (state == LOAD) && (count < SPAN);
  assign accept    = cmd_valid && cmd_ready;
  assign enc       = encode(cmd_kind, cmd_rd, cmd_rs1, cmd_rs2, cmd_imm);
  assign count_nx  = count + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      ovf_pend   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      count      <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum   <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      if (start) begin
        // A command arriving with start is dropped. The new session begins clean.
        state    <= LOAD;
        ovf_pend <= 1'b0;
        busy     <= 1'b1;
        done     <= 1'b0;
        err      <= 1'b0;
        count    <= '0;
`ifdef LOADER_CHECKSUM_EN
        checksum <= '0;
`endif
      end else begin
        case (state)
          LOAD: begin
            if (accept) begin
              imem_we    <= 1'b1;
              imem_addr  <= BASE_A + count[ADDR_W-1:0];
              imem_wdata <= enc;
              count      <= count_nx;
              if (imm_bad(cmd_kind, cmd_imm)) err <= 1'b1;
`ifdef LOADER_CHECKSUM_EN
              checksum   <= checksum ^ enc;
`endif
              if (cmd_last || count_nx == SPAN) begin
                state    <= DRAIN;
                ovf_pend <= !cmd_last;
              end
            end
          end
          DRAIN: begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            if (ovf_pend) err <= 1'b1;
          end
          default: ;  // IDLE and DONE ignore commands
        endcase
      end
    end
  end

endmodule
